// File: rtl/ram_unshifter.sv
// -----------------------------------------------------------------------------
// ram_unshifter
//
// Read-side partner of the BRAM serial shifter. It sweeps the read port of a
// BRAM delay line and rebuilds the 1-bit serial stream into parallel words.
// It accounts for the BRAM's synchronous read latency and starts reading at a
// fixed phase offset from the write pointer.
//
// Build option:
//   RAM_UNSHIFTER_OUTREG_EN  when defined, the BRAM output register is in use
//                            (DOA_REG=1). Read latency becomes 2 and ram_regce
//                            follows ram_en. When undefined, read latency is 1
//                            and ram_regce is tied low.
//
// Parameters:
//   IO_WIDTH     bits per reassembled word (>= 2)
//   ADDR_WIDTH   BRAM read address width
//   PHASE_SHIFT  first read address after a start, modulo 2^ADDR_WIDTH
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   en         run enable, level-sensitive
//   ram_addr   BRAM read address
//   ram_en     BRAM read enable (ENARDEN)
//   ram_regce  BRAM output register clock enable (REGCEAREGCE)
//   ram_out    serial read data (reduction-OR of the BRAM data bus)
//   out        last complete word, LSB = first bit sampled
//   out_valid  one-cycle strobe, high in the cycle out updates
//   overrun    sticky flag, set when the read address wraps while running
// -----------------------------------------------------------------------------
module ram_unshifter #(
  parameter int IO_WIDTH    = 16,
  parameter int ADDR_WIDTH  = 9,
  parameter int PHASE_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  output logic                  ram_regce,
  input  logic                  ram_out,
  output logic [IO_WIDTH-1:0]   out,
  output logic                  out_valid,
  output logic                  overrun
);

`ifdef RAM_UNSHIFTER_OUTREG_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

  localparam int CNT_W = $clog2(IO_WIDTH);

  // Truncation to ADDR_WIDTH bits is the modulo 2^ADDR_WIDTH reduction.
  localparam logic [ADDR_WIDTH-1:0] PHASE_ADDR = ADDR_WIDTH'(PHASE_SHIFT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
  localparam logic [CNT_W-1:0]      LAST_BIT   = CNT_W'(IO_WIDTH - 1);
  // The fill counter only has to count to LATENCY-1, which is at most 1.
  localparam logic                  FILL_LAST  = 1'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                  state_reg,     state_next;
  logic                    fill_cnt_reg,  fill_cnt_next;
  logic [CNT_W-1:0]        bit_cnt_reg,   bit_cnt_next;
  logic [IO_WIDTH-1:0]     shift_reg,     shift_next;
  logic [ADDR_WIDTH-1:0]   addr_reg,      addr_next;
  logic [IO_WIDTH-1:0]     out_reg,       out_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    overrun_reg,   overrun_next;

  // Incoming bit enters at the top and the word shifts right, so after
  // IO_WIDTH samples the first bit sits in bit 0 (LSB-first ordering).
  logic [IO_WIDTH-1:0]     shift_in;
  assign shift_in = {ram_out, shift_reg[IO_WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      fill_cnt_reg  <= 1'b0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      addr_reg      <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      addr_reg      <= addr_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      overrun_reg   <= overrun_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    fill_cnt_next  = fill_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    addr_next      = addr_reg;
    out_next       = out_reg;
    out_valid_next = 1'b0;
    overrun_next   = overrun_reg;

    case (state_reg)
      S_IDLE: begin
        // Start: load the phase offset and throw away any stale context.
        // out is left alone so the last good word stays visible.
        if (en) begin
          state_next    = S_FILL;
          addr_next     = PHASE_ADDR;
          fill_cnt_next = 1'b0;
          bit_cnt_next  = '0;
          shift_next    = '0;
          overrun_next  = 1'b0;
        end
      end

      S_FILL: begin
        // Address keeps moving while the read pipeline primes; nothing
        // coming out of the BRAM is meaningful yet. A wrap here is not an
        // overrun because no data has been consumed.
        if (!en) begin
          state_next = S_IDLE;
        end else begin
          addr_next = addr_reg + 1'b1;
          if (fill_cnt_reg == FILL_LAST) begin
            state_next    = S_RUN;
            fill_cnt_next = 1'b0;
          end else begin
            fill_cnt_next = fill_cnt_reg + 1'b1;
          end
        end
      end

      S_RUN: begin
        // The bit on ram_out belongs to this edge regardless of en, so a
        // word whose last bit lands as en falls still completes.
        shift_next = shift_in;
        if (bit_cnt_reg == LAST_BIT) begin
          out_next       = shift_in;
          out_valid_next = 1'b1;
          bit_cnt_next   = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end

        if (!en) begin
          state_next = S_IDLE;
        end else begin
          addr_next = addr_reg + 1'b1;
          if (addr_reg == ADDR_MAX) begin
            overrun_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_addr  = addr_reg;
  assign ram_en    = (state_reg != S_IDLE);
`ifdef RAM_UNSHIFTER_OUTREG_EN
  assign ram_regce = (state_reg != S_IDLE);
`else
  assign ram_regce = 1'b0;
`endif
  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule
